// File: rtl/huffman_stream_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : huffman_stream_aligner                                       |
// | Description : Bit-stream front end of the Huffman decoder. Keeps a         |
// |               left-aligned bit buffer fed from packed input words,         |
// |               presents the oldest C_W bits to the code-detect bank and     |
// |               emits the matched symbol over a valid/ready handshake.       |
// | Options     : HUFF_ALIGN_STATS_EN adds a saturating 16-bit symbol counter  |
// |               output (sym_cnt).                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module huffman_stream_aligner #(
  parameter int D_W  = 4,
  parameter int C_W  = 4,
  parameter int IN_W = 16,
  parameter int L_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            new_conf,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [C_W-1:0]  d2check,
  output logic            win_valid,
  input  logic            code_matched,
  input  logic [L_W-1:0]  code_len,
  input  logic [D_W-1:0]  data_encoded,
  output logic [D_W-1:0]  sym_out,
  output logic            sym_valid,
  output logic            sym_last,
  input  logic            sym_ready,
  output logic            err_nomatch
`ifdef HUFF_ALIGN_STATS_EN
  ,
  output logic [15:0]     sym_cnt
`endif
);

  localparam int c_buf_w  = 2 * IN_W;
  localparam int c_fill_w = $clog2(c_buf_w + 1);
  localparam logic [c_fill_w-1:0] c_in_w_f = c_fill_w'(IN_W);
  localparam logic [c_fill_w-1:0] c_room   = c_fill_w'(c_buf_w - IN_W);
  localparam logic [c_fill_w-1:0] c_cw_f   = c_fill_w'(C_W);
  localparam logic [L_W-1:0]      c_cw_len = L_W'(C_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_buf_w-1:0]  r_buf;
  logic [c_fill_w-1:0] r_fill;
  logic [D_W-1:0]      r_sym_out;
  logic                r_sym_valid;
  logic                r_sym_last;
  logic                r_err;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_win_valid;
  logic [c_fill_w-1:0] w_len_f;
  logic                w_len_bad;
  logic                w_lookup_err;
  logic                w_fire;
  logic [c_fill_w-1:0] w_consume;
  logic [c_fill_w-1:0] w_fill_after;
  logic [c_buf_w-1:0]  w_buf_shift;
  logic [c_buf_w-1:0]  w_word_ext;

  // Handshake, window and decode-fire decisions, all from registered state.
  always_comb begin
    w_in_ready   = ((r_state == S_IDLE) || (r_state == S_RUN)) && (r_fill <= c_room);
    w_accept     = in_valid && w_in_ready;
    w_win_valid  = ((r_state == S_RUN) && (r_fill >= c_cw_f)) ||
                   ((r_state == S_DRAIN) && (r_fill != '0));
    w_len_f      = c_fill_w'(code_len);
    w_len_bad    = (code_len == '0) || (code_len > c_cw_len) || (w_len_f > r_fill);
    w_lookup_err = w_win_valid && (!code_matched || w_len_bad);
    w_fire       = w_win_valid && code_matched && !w_len_bad &&
                   (!r_sym_valid || sym_ready);
    w_consume    = w_fire ? w_len_f : '0;
    w_fill_after = r_fill - w_consume;
    // Bits shifted in from the right are zero, so everything below the fill
    // level stays zero and a new word can simply be OR-ed in.
    w_buf_shift  = r_buf << w_consume;
    w_word_ext   = {in_data, {(c_buf_w - IN_W){1'b0}}};
  end

  // Buffer, fill level, stream state and registered symbol output.
  always_ff @(posedge clk) begin
    if (rst || new_conf) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_fill      <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
      r_sym_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // New word lands directly behind the bits that survive this cycle's consume.
      if (w_accept) begin
        r_buf  <= w_buf_shift | (w_word_ext >> w_fill_after);
        r_fill <= w_fill_after + c_in_w_f;
      end else begin
        r_buf  <= w_buf_shift;
        r_fill <= w_fill_after;
      end

      if (w_lookup_err) begin
        r_state <= S_ERR;
        r_err   <= 1'b1;
      end else if (w_accept) begin
        r_state <= in_last ? S_DRAIN : S_RUN;
      end else if ((r_state == S_DRAIN) && w_fire && (w_fill_after == '0)) begin
        r_state <= S_IDLE;
      end

      if (w_fire) begin
        r_sym_out   <= data_encoded;
        r_sym_valid <= 1'b1;
        r_sym_last  <= (r_state == S_DRAIN) && (w_fill_after == '0);
      end else if (r_sym_valid && sym_ready) begin
        r_sym_valid <= 1'b0;
        r_sym_last  <= 1'b0;
      end
    end
  end

`ifdef HUFF_ALIGN_STATS_EN
  logic [15:0] r_sym_cnt;

  // Saturating count of downstream symbol handshakes.
  always_ff @(posedge clk) begin
    if (rst || new_conf) begin
      r_sym_cnt <= '0;
    end else if (r_sym_valid && sym_ready && (r_sym_cnt != 16'hFFFF)) begin
      r_sym_cnt <= r_sym_cnt + 16'd1;
    end
  end

  assign sym_cnt = r_sym_cnt;
`endif

  assign in_ready    = w_in_ready;
  assign win_valid   = w_win_valid;
  assign d2check     = r_buf[c_buf_w-1 -: C_W];
  assign sym_out     = r_sym_out;
  assign sym_valid   = r_sym_valid;
  assign sym_last    = r_sym_last;
  assign err_nomatch = r_err;

endmodule
`default_nettype wire

// File: tb/tb_huffman_stream_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_huffman_stream_aligner                                    |
// | Description : Scoreboard bench for huffman_stream_aligner with a           |
// |               behavioural code bank (fixed, prefix and no-match modes).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_huffman_stream_aligner;

  logic        clk = 1'b0;
  logic        rst, new_conf;
  logic [15:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [3:0]  d2check;
  logic        win_valid, code_matched;
  logic [2:0]  code_len;
  logic [3:0]  data_encoded, sym_out;
  logic        sym_valid, sym_last, sym_ready, err_nomatch;
`ifdef HUFF_ALIGN_STATS_EN
  logic [15:0] sym_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          bank_mode;
  logic [4:0]  exp_q[$];
  logic [4:0]  sb_e;
  logic [3:0]  held_sym;
  logic [5:0]  held_fill;

  always #5 clk = ~clk;

  huffman_stream_aligner #(.D_W(4), .C_W(4), .IN_W(16), .L_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .new_conf     (new_conf),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .d2check      (d2check),
    .win_valid    (win_valid),
    .code_matched (code_matched),
    .code_len     (code_len),
    .data_encoded (data_encoded),
    .sym_out      (sym_out),
    .sym_valid    (sym_valid),
    .sym_last     (sym_last),
    .sym_ready    (sym_ready),
    .err_nomatch  (err_nomatch)
`ifdef HUFF_ALIGN_STATS_EN
    ,
    .sym_cnt      (sym_cnt)
`endif
  );

  // Code bank: 0 = fixed 4-bit ~c, 1 = prefix code {0,10,110,111}, 2 = never matches.
  always_comb begin
    code_matched = 1'b1;
    code_len     = 3'd4;
    data_encoded = 4'd0;
    case (bank_mode)
      0: data_encoded = ~d2check;
      1: begin
        if (!d2check[3]) begin
          code_len = 3'd1; data_encoded = 4'd1;
        end else if (!d2check[2]) begin
          code_len = 3'd2; data_encoded = 4'd2;
        end else if (!d2check[1]) begin
          code_len = 3'd3; data_encoded = 4'd3;
        end else begin
          code_len = 3'd3; data_encoded = 4'd4;
        end
      end
      default: code_matched = 1'b0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every downstream handshake.
  always @(negedge clk) begin
    if (sym_valid && sym_ready) begin
      check_val("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        check_val("sym_out", 32'(sym_out), 32'(sb_e[3:0]));
        check_val("sym_last", 32'(sym_last), 32'(sb_e[4]));
      end
    end
  end

  task automatic push_sym(input logic [3:0] s, input logic last);
    exp_q.push_back({last, s});
  endtask

  task automatic push_fixed(input logic [15:0] w, input logic last);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] nib;
      nib = w[i*4 +: 4];
      exp_q.push_back({last && (i == 0), ~nib});
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("in_ready_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_val(tag, exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic pulse_new_conf();
    @(negedge clk);
    new_conf = 1'b1;
    @(negedge clk);
    new_conf = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; new_conf = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    sym_ready = 1'b1; bank_mode = 0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 1);
    check_val("rst_d2check", 32'(d2check), 0);
    check_val("rst_win_valid", 32'(win_valid), 0);
    check_val("rst_sym_out", 32'(sym_out), 0);
    check_val("rst_sym_valid", 32'(sym_valid), 0);
    check_val("rst_sym_last", 32'(sym_last), 0);
    check_val("rst_err", 32'(err_nomatch), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_in_ready", 32'(in_ready), 1);
    check_val("idle_state", 32'(dut.r_state), 0);

    // Fixed-length single word: E,D,C,B with last on B
    push_fixed(16'h1234, 1'b1);
    send_word(16'h1234, 1'b1);
    wait_empty("fixed_drain");
    check_val("fixed_fill0", 32'(dut.r_fill), 0);
    check_val("fixed_idle", 32'(dut.r_state), 0);
    check_val("fixed_in_ready", 32'(in_ready), 1);
    check_val("fixed_sym_valid", 32'(sym_valid), 0);

    // Variable-length with a dangling trailing '1'
    bank_mode = 1;
    push_sym(4'd1, 0); push_sym(4'd2, 0); push_sym(4'd3, 0); push_sym(4'd4, 0);
    push_sym(4'd1, 0); push_sym(4'd2, 0); push_sym(4'd3, 0);
    send_word(16'h5BAD, 1'b1);
    n = 0;
    while (!err_nomatch && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("var_err", 32'(err_nomatch), 1);
    @(negedge clk);
    check_val("var_err_in_ready", 32'(in_ready), 0);
    check_val("var_err_win_valid", 32'(win_valid), 0);
    check_val("var_err_syms", exp_q.size(), 0);
    pulse_new_conf();
    check_val("var_clr_err", 32'(err_nomatch), 0);
    check_val("var_clr_in_ready", 32'(in_ready), 1);
    check_val("var_clr_fill", 32'(dut.r_fill), 0);

    // Variable-length ending on a code boundary
    push_sym(4'd1, 0); push_sym(4'd2, 0); push_sym(4'd3, 0); push_sym(4'd4, 0);
    push_sym(4'd1, 0); push_sym(4'd2, 0); push_sym(4'd3, 0); push_sym(4'd1, 1);
    send_word(16'h5BAC, 1'b1);
    wait_empty("var2_drain");
    check_val("var2_err", 32'(err_nomatch), 0);
    check_val("var2_fill0", 32'(dut.r_fill), 0);
    check_val("var2_in_ready", 32'(in_ready), 1);

    // Backpressure while streaming
    bank_mode = 0;
    push_fixed(16'h0123, 1'b0);
    push_fixed(16'h4567, 1'b0);
    push_fixed(16'h89AB, 1'b0);
    push_fixed(16'hCDEF, 1'b1);
    fork
      begin
        send_word(16'h0123, 1'b0);
        send_word(16'h4567, 1'b0);
        send_word(16'h89AB, 1'b0);
        send_word(16'hCDEF, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        sym_ready = 1'b0;
        @(negedge clk);
        held_sym  = sym_out;
        held_fill = dut.r_fill;
        check_val("bp_valid", 32'(sym_valid), 1);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check_val("bp_hold_sym", 32'(sym_out), 32'(held_sym));
          check_val("bp_fill_nodrop", 32'(dut.r_fill >= held_fill), 1);
        end
        check_val("bp_in_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        sym_ready = 1'b1;
      end
    join
    wait_empty("bp_drain");
    check_val("bp_fill0", 32'(dut.r_fill), 0);

    // No match while window valid
    bank_mode = 2;
    send_word(16'hABCD, 1'b0);
    @(negedge clk);
    check_val("nm_win_valid", 32'(win_valid), 1);
    check_val("nm_err_early", 32'(err_nomatch), 0);
    @(negedge clk);
    check_val("nm_err", 32'(err_nomatch), 1);
    check_val("nm_in_ready", 32'(in_ready), 0);
    pulse_new_conf();
    check_val("nm_clr_err", 32'(err_nomatch), 0);
    check_val("nm_clr_in_ready", 32'(in_ready), 1);
    check_val("nm_clr_idle", 32'(dut.r_state), 0);

    // Flush mid-stream with fill=20 and a symbol pending
    bank_mode = 0;
    push_fixed(16'h1111, 1'b0);
    push_fixed(16'h2222, 1'b0);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(dut.r_fill == 6'd20 && sym_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("fl_reach20", 32'(dut.r_fill), 20);
    new_conf = 1'b1;
    @(negedge clk);
    new_conf = 1'b0;
    exp_q.delete();
    check_val("fl_fill0", 32'(dut.r_fill), 0);
    check_val("fl_sym_valid", 32'(sym_valid), 0);
    check_val("fl_in_ready", 32'(in_ready), 1);
`ifdef HUFF_ALIGN_STATS_EN
    check_val("fl_sym_cnt", 32'(sym_cnt), 0);
`endif
    push_fixed(16'hBEEF, 1'b1);
    send_word(16'hBEEF, 1'b1);
    wait_empty("fl_after_drain");
    check_val("fl_after_fill0", 32'(dut.r_fill), 0);
`ifdef HUFF_ALIGN_STATS_EN
    check_val("fl_after_sym_cnt", 32'(sym_cnt), 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
